// File: rtl/gf_pkg.sv
// gf_pkg: shared constants and FSM state type for the GF(2^8) sequential reducer.
package gf_pkg;

    localparam logic [7:0] GF_POLY_AES = 8'h1B;
    localparam int         GF_M        = 8;
    localparam int         GF_PROD_W   = 15;

    // Remainder bit index range walked by the reducer, top down.
    localparam logic [3:0] GF_K_TOP    = 4'd14;
    localparam logic [3:0] GF_K_BOT    = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } gf_state_t;

endpackage

// File: rtl/gf_reduce_step.sv
// gf_reduce_step: one conditional XOR step of polynomial reduction.
// If bit k of r is set (and k is a bit above the field degree), the shifted
// field polynomial is XORed in so that bit k is cleared; otherwise r passes.
module gf_reduce_step
    import gf_pkg::*;
(
    input  logic [GF_PROD_W-1:0] r,
    input  logic [3:0]           k,
    input  logic [GF_M-1:0]      poly,
    output logic [GF_PROD_W-1:0] r_next
);

    logic [GF_PROD_W-1:0] poly_shifted;
    logic                 hit;

    // Align {x^8 + poly} under bit k and clear that bit when it is set.
    always_comb begin
        poly_shifted = {{(GF_PROD_W-GF_M-1){1'b0}}, 1'b1, poly} << k[2:0];
        hit          = (k >= GF_K_BOT) && (k <= GF_K_TOP) && r[k];
        r_next       = hit ? (r ^ poly_shifted) : r;
    end

endmodule

// File: rtl/gf_reduce_seq.sv
// gf_reduce_seq: sequential reduction of a 15-bit carry-less product modulo
// x^8 + POLY, one bit per cycle from bit 14 down to bit 8.
// Optional macro GF_REDUCE_FAST_EN: two reduction bits per cycle (4-cycle
// REDUCE phase instead of 7); results are identical in both builds.
module gf_reduce_seq
    import gf_pkg::*;
#(
    parameter logic [7:0] POLY = GF_POLY_AES
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GF_PROD_W-1:0] in_prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GF_M-1:0]      out_res,
    output logic                 busy
);

    gf_state_t            state;
    gf_state_t            state_next;
    logic [GF_PROD_W-1:0] r;
    logic [GF_PROD_W-1:0] r_next;
    logic [3:0]           k;
    logic [3:0]           k_next;
    logic [GF_PROD_W-1:0] r_step;

`ifdef GF_REDUCE_FAST_EN
    localparam logic [3:0] K_STRIDE = 4'd2;

    logic [GF_PROD_W-1:0] r_mid;
    logic [GF_PROD_W-1:0] r_pair;
    logic [3:0]           k_lo;

    assign k_lo = k - 4'd1;

    gf_reduce_step u_step_hi (
        .r      (r),
        .k      (k),
        .poly   (POLY),
        .r_next (r_mid)
    );

    gf_reduce_step u_step_lo (
        .r      (r_mid),
        .k      (k_lo),
        .poly   (POLY),
        .r_next (r_pair)
    );

    // The last pair would reach below the field degree, so bit 8 goes alone.
    assign r_step = (k == GF_K_BOT) ? r_mid : r_pair;
`else
    localparam logic [3:0] K_STRIDE = 4'd1;

    gf_reduce_step u_step (
        .r      (r),
        .k      (k),
        .poly   (POLY),
        .r_next (r_step)
    );
`endif

    // State, remainder and bit index registers; reset discards any work in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            k     <= GF_K_TOP;
        end else begin
            state <= state_next;
            r     <= r_next;
            k     <= k_next;
        end
    end

    // Next-state and datapath update: load on accept, reduce until bit 8, hold in DONE.
    always_comb begin
        state_next = state;
        r_next     = r;
        k_next     = k;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    r_next     = in_prod;
                    k_next     = GF_K_TOP;
                    state_next = REDUCE;
                end
            end
            REDUCE: begin
                r_next = r_step;
                k_next = k - K_STRIDE;
                if (k <= GF_K_BOT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_res   = r[GF_M-1:0];

endmodule

// File: tb/tb_gf_reduce_seq.sv
// tb_gf_reduce_seq: self-checking bench for gf_reduce_seq.
// Reference results come from GF(2^8) arithmetic (powers of x, and
// shift-and-add field multiplication), not from long division.
module tb_gf_reduce_seq;

    localparam logic [7:0] TB_POLY = 8'h1B;
`ifdef GF_REDUCE_FAST_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 7;
`endif
    localparam int N_RAND = 1000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_res;
    logic        busy;

    int total;
    int bad;

    logic [7:0] pow_tab [15];

    gf_reduce_seq #(.POLY(TB_POLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? TB_POLY : 8'h00);
    endfunction

    // Reduction by linearity: the residue is the XOR of x^i mod P over set bits.
    function automatic logic [7:0] ref_mod(input logic [14:0] p);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 15; i++) if (p[i]) acc ^= pow_tab[i];
        return acc;
    endfunction

    function automatic logic [14:0] clmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) if (b[i]) acc ^= ({7'b0, a} << i);
        return acc;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Present a product and wait (bounded) for the accept edge; leaves us at edge+1.
    task automatic do_accept(input logic [14:0] p, output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_prod  = p;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_prod  = 15'($urandom);
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic do_release();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got valid/busy/ready=%b required 000", {out_valid, busy, in_ready});
        end
        total++;
        if (out_res !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_res: got %h required 00", out_res);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_ready: got ready=%b busy=%b required ready=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [14:0] d_prod [6];
        logic [7:0]  d_exp  [6];
        bit ok;
        int cyc;
        d_prod = '{15'h0100, 15'h3F7E, 15'h4000, 15'h00FF, 15'h0000, 15'h7FFF};
        d_exp  = '{8'h1B,    8'h01,    8'h9A,    8'hFF,    8'h00,    ref_mod(15'h7FFF)};
        for (int i = 0; i < 6; i++) begin
            do_accept(d_prod[i], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("[TB] FAIL directed_accept[%0d]: in_ready stayed low", i);
            end
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL directed_busy[%0d]: got busy=%b ready=%b required 1/0", i, busy, in_ready);
            end
            wait_valid(cyc);
            total++;
            if (cyc != LAT) begin
                bad++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d required %0d", i, cyc, LAT);
            end
            total++;
            if (out_res !== d_exp[i]) begin
                bad++;
                $display("[TB] FAIL directed_res[%0d] prod=%h: got %h required %h", i, d_prod[i], out_res, d_exp[i]);
            end
            do_release();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL directed_release[%0d]: got valid=%b ready=%b required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        do_accept(15'h3F7E, ok);
        wait_valid(cyc);
        total++;
        if (cyc != LAT) begin
            bad++;
            $display("[TB] FAIL stall_latency: got %0d required %0d", cyc, LAT);
        end
        in_valid = 1'b1;
        in_prod  = 15'h4000;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_res !== 8'h01 || in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b res=%h ready=%b required 1/01/0",
                         i, out_valid, out_res, in_ready);
            end
        end
        do_release();
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_no_same_edge_accept: got busy=%b ready=%b valid=%b required 0/1/0",
                     busy, in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        bit seen;
        do_accept(15'h4000, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_res !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_mid_now: got valid/busy/ready=%b res=%h required 000/00",
                     {out_valid, busy, in_ready}, out_res);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_discard: got out_valid seen=%b required 0", seen);
        end
        do_accept(15'h0100, ok);
        wait_valid(cyc);
        total++;
        if (cyc != LAT || out_res !== 8'h1B) begin
            bad++;
            $display("[TB] FAIL reset_mid_next: got lat=%0d res=%h required lat=%0d res=1b", cyc, out_res, LAT);
        end
        do_release();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q [$];
        logic [7:0]  pend_exp;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  want;
        logic [14:0] p;
        int sent;
        int delivered;
        int cycles;
        int errs;
        bit acc;
        sent      = 0;
        delivered = 0;
        cycles    = 0;
        errs      = 0;
        pend_exp  = 8'h00;
        while (delivered < N_RAND && cycles < 40000) begin
            if (!in_valid && sent < N_RAND && $urandom_range(0, 7) != 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    a        = 8'($urandom);
                    b        = 8'($urandom);
                    p        = clmul(a, b);
                    pend_exp = gf_mul(a, b);
                end else begin
                    p        = 15'($urandom);
                    pend_exp = ref_mod(p);
                end
                in_valid = 1'b1;
                in_prod  = p;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(pend_exp);
                sent++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    errs++;
                    $display("[TB] FAIL stream_unexpected: got res=%h with nothing outstanding", out_res);
                end else begin
                    want = q.pop_front();
                    if (out_res !== want) begin
                        bad++;
                        errs++;
                        if (errs < 10)
                            $display("[TB] FAIL stream_res[%0d]: got %h required %h", delivered, out_res, want);
                    end
                end
                delivered++;
            end
            @(posedge clk); #1;
            cycles++;
            if (acc) begin
                in_valid = 1'b0;
                in_prod  = 15'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (delivered != N_RAND || q.size() != 0) begin
            bad++;
            $display("[TB] FAIL stream_count: got delivered=%0d left=%0d required %0d/0", delivered, q.size(), N_RAND);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pow_tab[0] = 8'h01;
        for (int i = 1; i < 15; i++) pow_tab[i] = xtime(pow_tab[i-1]);
        $display("[TB] starting, latency %0d", LAT);
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf_reduce_seq.md
GF_REDUCE_SEQ -- requirements
Module: gf_reduce_seq

Interface
REQ-001 The block SHALL take parameter POLY, default 8'h1B, as the low byte of the monic degree-8 field polynomial (x^8 implied; default x^8+x^4+x^3+x+1).
REQ-002 The block SHALL have port clk, input, 1 bit, as the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, as the asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, set high when in_prod is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, set high when the block can accept a product.
REQ-006 The block SHALL have port in_prod, input, 15 bits, as the carry-less 8x8 product from the upstream OKA multiplier (coefficient of x^i in bit i).
REQ-007 The block SHALL have port out_valid, output, 1 bit, set high when out_res holds a reduced result.
REQ-008 The block SHALL have port out_ready, input, 1 bit, set high when the consumer accepts out_res.
REQ-009 The block SHALL have port out_res, output, 8 bits, carrying in_prod mod (x^8+POLY).
REQ-010 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 The block SHALL use an FSM with three states: IDLE, REDUCE and DONE.
REQ-012 in_ready SHALL be high only in IDLE, and the block SHALL accept a product on a rising edge where in_valid && in_ready.
REQ-013 On accept, the block SHALL load in_prod into a 15-bit remainder register r, set the bit index k to 14 and enter REDUCE.
REQ-014 In REDUCE, each edge SHALL apply: if r[k]==1, r ^= {1'b1,POLY} << (k-8); then k decrements.
REQ-015 REDUCE SHALL process bits 14 down to 8, which is exactly 7 edges, then enter DONE.
REQ-016 out_valid SHALL be high exactly in DONE, with out_res = r[7:0], held stable until the handshake.
REQ-017 out_valid SHALL rise 7 cycles after the accept edge, and peak throughput SHALL be one product per 9 cycles.
REQ-018 In DONE with out_ready high, the block SHALL return to IDLE on that edge, with no same-edge accept of a new input.
REQ-019 In DONE with out_ready low, the block SHALL stay in DONE indefinitely, keeping out_res and out_valid unchanged.
REQ-020 in_valid SHALL be ignored outside IDLE, and in_prod SHALL not be sampled after the accept edge.
REQ-021 in_prod[14:8]==0 SHALL still take the full latency, and in that case out_res SHALL equal in_prod[7:0].
REQ-022 out_res SHALL be driven from r[7:0] in every state, and its value SHALL be meaningful only while out_valid is high.

Reset
REQ-023 Assertion of rst_n low, in any state including mid-REDUCE, SHALL immediately force IDLE, r=0 and k=14.
REQ-024 During reset the outputs SHALL be out_valid=0, out_res=0, busy=0 and in_ready=0.
REQ-025 in_ready SHALL be high from the first clock after rst_n deasserts.
REQ-026 A result in progress at reset SHALL be discarded and never presented.

Configuration
REQ-027 When GF_REDUCE_FAST_EN is defined, each REDUCE edge SHALL process bit k then bit k-1, sequentially, in the same cycle; k SHALL decrement by 2, with the final edge processing bit 8 only.
REQ-028 With GF_REDUCE_FAST_EN defined, REDUCE SHALL last 4 edges, covering bits {14,13},{12,11},{10,9},{8}, and out_valid SHALL rise 4 cycles after accept.
REQ-029 Without GF_REDUCE_FAST_EN, the behaviour of REQ-014 to REQ-017 SHALL apply, and results SHALL be identical in both builds.

Structure
REQ-030 Package gf_pkg SHALL hold GF_POLY_AES (8'h1B), GF_M (8), GF_PROD_W (15) and the FSM state enum.
REQ-031 The single-bit conditional XOR step SHALL be the combinational sub-module gf_reduce_step (inputs r, k, poly; output next r), instanced twice when GF_REDUCE_FAST_EN is defined.

Verification
REQ-032 in_prod=15'h0100 -> out_res=8'h1B, with out_valid at accept+7 (accept+4 when FAST).
REQ-033 in_prod=15'h3F7E (0x53 (x) 0xCA) -> out_res=8'h01; in_prod=15'h4000 -> out_res=8'h9A.
REQ-034 in_prod=15'h00FF -> out_res=8'hFF, with unchanged latency.
REQ-035 out_ready held low for 20 cycles in DONE -> out_valid and out_res stable, in_ready=0, and a second in_valid is not accepted.
REQ-036 rst_n pulsed low at the 3rd REDUCE cycle -> immediate IDLE with out_valid=0; the next product 15'h0100 -> 8'h1B with normal latency.
REQ-037 A random back-to-back stream of 1000 products with a random out_ready pattern -> every out_res matches the reference model of a carry-less product mod x^8+POLY, in order and with none lost.
